// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: round-robin arbiter that lends one combinational ALU to two
// requesters. One operation is in flight at a time: the winner's operands are
// registered onto the ALU, held for EXEC_CYCLES, and the sampled result is
// returned on the winner's response channel.
module alu_share_ctrl #(
   parameter int WIDTH       = 4,
   parameter int OPW         = 3,
   parameter int EXEC_CYCLES = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [OPW-1:0]   req0_op,
   output logic             rsp0_valid,
   input  logic             rsp0_ready,
   output logic [WIDTH-1:0] rsp0_result,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [OPW-1:0]   req1_op,
   output logic             rsp1_valid,
   input  logic             rsp1_ready,
   output logic [WIDTH-1:0] rsp1_result,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [OPW-1:0]   alu_op,
   input  logic [WIDTH-1:0] alu_result,
   output logic             busy
);

   // Counter only needs to hold EXEC_CYCLES-1; keep at least one bit.
   localparam int CNT_W = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t           state_q, state_d;
   logic             ptr_q, ptr_d;       // 1: requester 1 favoured on contention
   logic             owner_q, owner_d;   // requester that owns the in-flight op
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] alu_a_q, alu_a_d;
   logic [WIDTH-1:0] alu_b_q, alu_b_d;
   logic [OPW-1:0]   alu_op_q, alu_op_d;
   logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
   logic             grant1;

   // Next-state logic: arbitration in IDLE, settle countdown in EXEC, handshake in RESP.
   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      owner_d      = owner_q;
      cnt_d        = cnt_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      alu_op_d     = alu_op_q;
      rsp_result_d = rsp_result_q;
      grant1       = 1'b0;
      req0_ready   = 1'b0;
      req1_ready   = 1'b0;
      case (state_q)
         IDLE: begin
            if (req0_valid || req1_valid) begin
               // Requester 1 wins when it is alone, or when both ask and it is favoured.
               grant1     = req1_valid && (!req0_valid || ptr_q);
               req0_ready = !grant1;
               req1_ready = grant1;
               owner_d    = grant1;
               alu_a_d    = grant1 ? req1_a  : req0_a;
               alu_b_d    = grant1 ? req1_b  : req0_b;
               alu_op_d   = grant1 ? req1_op : req0_op;
               cnt_d      = CNT_W'(EXEC_CYCLES - 1);
               state_d    = EXEC;
            end
         end
         EXEC: begin
            if (cnt_q == '0) begin
               rsp_result_d = alu_result;
               state_d      = RESP;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         RESP: begin
            if (owner_q ? rsp1_ready : rsp0_ready) begin
               ptr_d   = !owner_q;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset drops any in-flight operation.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         ptr_q        <= 1'b0;
         owner_q      <= 1'b0;
         cnt_q        <= '0;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_op_q     <= '0;
         rsp_result_q <= '0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         owner_q      <= owner_d;
         cnt_q        <= cnt_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         alu_op_q     <= alu_op_d;
         rsp_result_q <= rsp_result_d;
      end
   end

   assign alu_a       = alu_a_q;
   assign alu_b       = alu_b_q;
   assign alu_op      = alu_op_q;
   assign rsp0_result = rsp_result_q;
   assign rsp1_result = rsp_result_q;
   assign rsp0_valid  = (state_q == RESP) && !owner_q;
   assign rsp1_valid  = (state_q == RESP) &&  owner_q;
   assign busy        = (state_q != IDLE);

endmodule
